// File: rtl/load_unit.sv
//==============================================================================
// Module  : load_unit
// Brief   : Load unit that decodes the region, waits on DMEM/BIOS/MMIO and
//           returns an aligned, extended result. LOAD_MISALIGN_TRAP_EN makes
//           misaligned LH/LHU/LW loads return an error.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module load_unit #(
    parameter int unsigned MMIO_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] dmem_dout,
    input  logic [31:0] bios_dout,
    input  logic [31:0] mmio_rdata,
    input  logic        mmio_rvalid,
    output logic        mmio_re,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MEM  = 2'd1;
    localparam logic [1:0] c_ST_MMIO = 2'd2;
    localparam logic [1:0] c_ST_RESP = 2'd3;

    localparam int c_CNT_W = (MMIO_TIMEOUT < 2) ? 1 : $clog2(MMIO_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(MMIO_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic               r_req_ready;
    logic               r_mmio_re;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_data;
    logic               r_rsp_err;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic               r_src_bios;

    logic w_is_mmio;
    logic w_is_bios;
    logic w_mapped;
    logic w_f3_ok;
    logic w_misalign;
    logic w_req_err;
    logic w_unused;

    assign w_is_mmio = addr[31];
    assign w_is_bios = !addr[31] && addr[30];
    assign w_mapped  = addr[31] || addr[30] || addr[28];

    always_comb begin
        w_f3_ok = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
            default:                                w_f3_ok = 1'b0;
        endcase
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    // funct3[1:0]==01 covers both LH and LHU
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err = !w_mapped || !w_f3_ok || w_misalign;
    assign w_unused  = ^{addr[29], addr[27:2]};

    function automatic logic [31:0] f_align(
        input logic [31:0] data,
        input logic [2:0]  f3,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return data;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_req_ready <= 1'b1;
            r_mmio_re   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
            r_funct3    <= 3'd0;
            r_off       <= 2'd0;
            r_src_bios  <= 1'b0;
        end else begin
            r_mmio_re   <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_funct3    <= funct3;
                        r_off       <= addr[1:0];
                        r_src_bios  <= w_is_bios;
                        r_req_ready <= 1'b0;
                        if (w_req_err) begin
                            r_state     <= c_ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'd0;
                        end else if (w_is_mmio) begin
                            r_state   <= c_ST_MMIO;
                            r_mmio_re <= 1'b1;
                            r_cnt     <= c_CNT_ONE;
                        end else begin
                            r_state <= c_ST_MEM;
                        end
                    end
                end
                c_ST_MEM: begin
                    r_rsp_data  <= f_align(r_src_bios ? bios_dout : dmem_dout, r_funct3, r_off);
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_ST_RESP;
                end
                c_ST_MMIO: begin
                    // Data arriving on the timeout cycle still wins
                    if (mmio_rvalid) begin
                        r_rsp_data  <= f_align(mmio_rdata, r_funct3, r_off);
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                        r_cnt       <= '0;
                    end else if (r_cnt >= c_TIMEOUT) begin
                        r_rsp_data  <= 32'd0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_ST_RESP;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_RESP: begin
                    r_state     <= c_ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign mmio_re   = r_mmio_re;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
//==============================================================================
// Module  : tb_load_unit
// Brief   : Self-checking bench for load_unit against a behavioural model.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] dmem_dout;
    logic [31:0] bios_dout;
    logic [31:0] mmio_rdata;
    logic        mmio_rvalid;
    logic        mmio_re;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int vectors;
    int miscompares;

    logic [2:0] valid_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    load_unit #(.MMIO_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .addr        (addr),
        .funct3      (funct3),
        .dmem_dout   (dmem_dout),
        .bios_dout   (bios_dout),
        .mmio_rdata  (mmio_rdata),
        .mmio_rvalid (mmio_rvalid),
        .mmio_re     (mmio_re),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: latency counted in cycles after the accept edge
    function automatic void model(
        input  logic [31:0] a,
        input  logic [2:0]  f,
        input  logic [31:0] dw, bw, mw,
        input  int          d,
        output int          e_lat,
        output logic [31:0] e_data,
        output logic        e_err,
        output int          e_re
    );
        logic [31:0] word;
        logic [31:0] sh;
        logic        ok_f3;
        logic        mis;
        int          region;
        if (a[31])      region = 0;
        else if (a[30]) region = 1;
        else if (a[28]) region = 2;
        else            region = 3;
        ok_f3 = (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
        mis = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
        if ((f == 3'd1 || f == 3'd5) && (a % 2 != 0)) mis = 1'b1;
        if (f == 3'd2 && (a % 4 != 0))                mis = 1'b1;
`endif
        e_re = 0;
        if (region == 3 || !ok_f3 || mis) begin
            e_lat = 1; e_err = 1'b1; e_data = 32'd0;
            return;
        end
        if (region == 0) begin
            e_re = 1;
            if (d < 0 || d >= TO) begin
                e_lat = TO + 1; e_err = 1'b1; e_data = 32'd0;
                return;
            end
            e_lat = d + 2;
            word  = mw;
        end else begin
            e_lat = 2;
            word  = (region == 1) ? bw : dw;
        end
        e_err = 1'b0;
        if (f == 3'd0 || f == 3'd4) begin
            sh = (word >> (8 * (a % 4))) & 32'hFF;
            if (f == 3'd0 && sh >= 32'd128) sh = sh | 32'hFFFF_FF00;
        end else if (f == 3'd1 || f == 3'd5) begin
            sh = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (f == 3'd1 && sh >= 32'h8000) sh = sh | 32'hFFFF_0000;
        end else begin
            sh = word;
        end
        e_data = sh;
    endfunction

    // Issues one load and records what the DUT returns (no checking here)
    task automatic run_load(
        input  logic [31:0] a,
        input  logic [2:0]  f,
        input  logic [31:0] dw, bw, mw,
        input  int          d,
        output int          lat,
        output logic [31:0] data,
        output logic        err,
        output int          re_cnt,
        output int          re_first,
        output logic        ready_after,
        output logic        valid_after,
        output logic [31:0] data_after
    );
        int w;
        w = 0;
        while (req_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        req_valid   = 1'b1;
        addr        = a;
        funct3      = f;
        dmem_dout   = ~dw;
        bios_dout   = ~bw;
        mmio_rvalid = 1'($urandom_range(0, 1));
        mmio_rdata  = $urandom;
        tick();
        req_valid = 1'b0;
        addr      = $urandom;
        funct3    = 3'($urandom);
        dmem_dout = dw;
        bios_dout = bw;
        lat = -1; data = 32'd0; err = 1'b0; re_cnt = 0; re_first = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (mmio_re === 1'b1) begin
                re_cnt++;
                if (re_first < 0) re_first = k;
            end
            if (rsp_valid === 1'b1) begin
                lat = k; data = rsp_data; err = rsp_err;
            end
            if (re_first < 0) mmio_rvalid = 1'($urandom_range(0, 1));
            else              mmio_rvalid = (d >= 0 && k == re_first + d);
            mmio_rdata = mmio_rvalid ? mw : $urandom;
            tick();
            dmem_dout = $urandom;
            bios_dout = $urandom;
        end
        mmio_rvalid = 1'b0;
        ready_after = req_ready;
        valid_after = rsp_valid;
        data_after  = rsp_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; addr = 32'd0; funct3 = 3'd0;
        dmem_dout = 32'd0; bios_dout = 32'd0; mmio_rdata = 32'd0; mmio_rvalid = 1'b1;
        tick();
        tick();
        vectors++; if (req_ready !== 1'b1)  begin miscompares++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
        vectors++; if (mmio_re !== 1'b0)    begin miscompares++; $display("FAIL reset mmio_re: got %b expected 0", mmio_re); end
        vectors++; if (rsp_valid !== 1'b0)  begin miscompares++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
        vectors++; if (rsp_data !== 32'd0)  begin miscompares++; $display("FAIL reset rsp_data: got %h expected 0", rsp_data); end
        vectors++; if (rsp_err !== 1'b0)    begin miscompares++; $display("FAIL reset rsp_err: got %b expected 0", rsp_err); end
        mmio_rvalid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        int lat, re_cnt, re_first;
        logic [31:0] data, data_after;
        logic err, ready_after, valid_after;
        run_load(32'h1000_0003, 3'b000, 32'h80FF_0000, 32'd0, 32'd0, -1,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (lat !== 2)                 begin miscompares++; $display("FAIL dmem_lb latency: got %0d expected 2", lat); end
        vectors++; if (data !== 32'hFFFF_FF80)    begin miscompares++; $display("FAIL dmem_lb data: got %h expected ffffff80", data); end
        vectors++; if (err !== 1'b0)              begin miscompares++; $display("FAIL dmem_lb err: got %b expected 0", err); end
        vectors++; if (valid_after !== 1'b0)      begin miscompares++; $display("FAIL dmem_lb one-cycle valid: got %b expected 0", valid_after); end
        vectors++; if (data_after !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL dmem_lb data hold: got %h expected ffffff80", data_after); end

        run_load(32'h4000_0002, 3'b101, 32'd0, 32'hBEEF_1234, 32'd0, -1,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (data !== 32'h0000_BEEF)    begin miscompares++; $display("FAIL bios_lhu data: got %h expected 0000beef", data); end
        vectors++; if (lat !== 2)                 begin miscompares++; $display("FAIL bios_lhu latency: got %0d expected 2", lat); end

        run_load(32'h8000_0010, 3'b010, 32'd0, 32'd0, 32'hDEAD_BEEF, 3,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (re_cnt !== 1)              begin miscompares++; $display("FAIL mmio_lw re pulses: got %0d expected 1", re_cnt); end
        vectors++; if (re_first !== 1)            begin miscompares++; $display("FAIL mmio_lw re cycle: got %0d expected 1", re_first); end
        vectors++; if (data !== 32'hDEAD_BEEF)    begin miscompares++; $display("FAIL mmio_lw data: got %h expected deadbeef", data); end
        vectors++; if (err !== 1'b0)              begin miscompares++; $display("FAIL mmio_lw err (data on timeout cycle): got %b expected 0", err); end
        vectors++; if (lat !== 5)                 begin miscompares++; $display("FAIL mmio_lw latency: got %0d expected 5", lat); end
    endtask

    task automatic test_timeout();
        int lat, re_cnt, re_first;
        logic [31:0] data, data_after;
        logic err, ready_after, valid_after;
        run_load(32'h8000_0020, 3'b010, 32'd0, 32'd0, 32'h1234_5678, -1,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (lat !== TO + 1)            begin miscompares++; $display("FAIL timeout latency: got %0d expected %0d", lat, TO + 1); end
        vectors++; if (err !== 1'b1)              begin miscompares++; $display("FAIL timeout err: got %b expected 1", err); end
        vectors++; if (data !== 32'd0)            begin miscompares++; $display("FAIL timeout data: got %h expected 0", data); end
        vectors++; if (ready_after !== 1'b1)      begin miscompares++; $display("FAIL timeout ready after: got %b expected 1", ready_after); end
    endtask

    task automatic test_errors();
        int lat, re_cnt, re_first;
        logic [31:0] data, data_after;
        logic err, ready_after, valid_after;
        run_load(32'h1000_0000, 3'b011, 32'hFFFF_FFFF, 32'd0, 32'd0, -1,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (lat !== 1 || err !== 1'b1) begin miscompares++; $display("FAIL bad_funct3: got lat %0d err %b expected lat 1 err 1", lat, err); end
        vectors++; if (data !== 32'd0)            begin miscompares++; $display("FAIL bad_funct3 data: got %h expected 0", data); end
        run_load(32'h0000_0000, 3'b010, 32'hFFFF_FFFF, 32'd0, 32'd0, -1,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (lat !== 1 || err !== 1'b1) begin miscompares++; $display("FAIL unmapped: got lat %0d err %b expected lat 1 err 1", lat, err); end
        run_load(32'h8000_0000, 3'b111, 32'd0, 32'd0, 32'hFFFF_FFFF, 0,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (re_cnt !== 0)              begin miscompares++; $display("FAIL mmio bad_funct3 re: got %0d expected 0", re_cnt); end
        vectors++; if (lat !== 1 || err !== 1'b1) begin miscompares++; $display("FAIL mmio bad_funct3: got lat %0d err %b expected lat 1 err 1", lat, err); end
        run_load(32'h1000_0001, 3'b010, 32'hCAFE_F00D, 32'd0, 32'd0, -1,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
`ifdef LOAD_MISALIGN_TRAP_EN
        vectors++; if (lat !== 1 || err !== 1'b1) begin miscompares++; $display("FAIL misaligned lw: got lat %0d err %b expected lat 1 err 1", lat, err); end
`else
        vectors++; if (lat !== 2 || data !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL misaligned lw: got lat %0d data %h expected lat 2 data cafef00d", lat, data); end
`endif
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat, re_cnt, re_first;
        logic [31:0] data, data_after;
        logic err, ready_after, valid_after;
        req_valid = 1'b1; addr = 32'h8000_0004; funct3 = 3'b010;
        tick();
        req_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        vectors++; if (req_ready !== 1'b1 || mmio_re !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset outputs: got ready %b re %b valid %b data %h err %b expected 1 0 0 0 0", req_ready, mmio_re, rsp_valid, rsp_data, rsp_err);
        end
        tick();
        rst_n = 1'b1;
        mmio_rvalid = 1'b1; mmio_rdata = 32'h1234_5678;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (rsp_valid === 1'b1) seen++;
        end
        mmio_rvalid = 1'b0;
        vectors++; if (seen !== 0)               begin miscompares++; $display("FAIL midreset late rvalid: got %0d responses expected 0", seen); end
        vectors++; if (rsp_data !== 32'd0)       begin miscompares++; $display("FAIL midreset rsp_data: got %h expected 0", rsp_data); end
        run_load(32'h1000_0008, 3'b010, 32'h0BAD_CAFE, 32'd0, 32'd0, -1,
                 lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
        vectors++; if (lat !== 2 || data !== 32'h0BAD_CAFE || err !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset next load: got lat %0d data %h err %b expected 2 0badcafe 0", lat, data, err);
        end
    endtask

    task automatic test_random(input int n, input string tag);
        logic [31:0] a, dw, bw, mw, data, e_data, data_after;
        logic [2:0]  f;
        logic        err, e_err, ready_after, valid_after;
        int d, sel, lat, e_lat, re_cnt, re_first, e_re;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       a[31] = 1'b1;
                1:       begin a[31] = 1'b0; a[30] = 1'b1; end
                2:       begin a[31:30] = 2'b00; a[28] = 1'b1; end
                default: begin a[31:30] = 2'b00; a[28] = 1'b0; end
            endcase
            if ($urandom_range(0, 7) == 0) f = 3'($urandom);
            else                           f = valid_f3[$urandom_range(0, 4)];
            dw = $urandom; bw = $urandom; mw = $urandom;
            d = int'($urandom_range(0, 6)) - 1;
            model(a, f, dw, bw, mw, d, e_lat, e_data, e_err, e_re);
            run_load(a, f, dw, bw, mw, d, lat, data, err, re_cnt, re_first, ready_after, valid_after, data_after);
            vectors++; if (lat !== e_lat)    begin miscompares++; $display("FAIL %s[%0d] latency a=%h f=%0d d=%0d: got %0d expected %0d", tag, i, a, f, d, lat, e_lat); end
            vectors++; if (data !== e_data)  begin miscompares++; $display("FAIL %s[%0d] data a=%h f=%0d: got %h expected %h", tag, i, a, f, data, e_data); end
            vectors++; if (err !== e_err)    begin miscompares++; $display("FAIL %s[%0d] err a=%h f=%0d: got %b expected %b", tag, i, a, f, err, e_err); end
            vectors++; if (re_cnt !== e_re)  begin miscompares++; $display("FAIL %s[%0d] mmio_re count: got %0d expected %0d", tag, i, re_cnt, e_re); end
            vectors++; if (ready_after !== 1'b1 || valid_after !== 1'b0 || data_after !== e_data) begin
                miscompares++;
                $display("FAIL %s[%0d] after resp: got ready %b valid %b data %h expected 1 0 %h", tag, i, ready_after, valid_after, data_after, e_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        test_random(12, "b2b");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_timeout();
        test_errors();
        test_reset_mid();
        test_random(150, "rand");
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
